// File: rtl/jtvigil_sdram_resp_if.sv
// Four-bank SDRAM read bundle between the game's mux (master) and the bank responder (slave),
// plus the responder's fixed-latency memory read port.
interface jtvigil_sdram_resp_if;
    logic [21:0] ba0_addr;
    logic [21:0] ba1_addr;
    logic [21:0] ba2_addr;
    logic [21:0] ba3_addr;
    logic [3:0]  ba_rd;
    logic [3:0]  ba_ack;
    logic [3:0]  ba_dst;
    logic [3:0]  ba_dok;
    logic [3:0]  ba_rdy;
    logic [15:0] data_read;
    logic [21:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data;

    modport slave (
        input  ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd, mem_data,
        output ba_ack, ba_dst, ba_dok, ba_rdy, data_read, mem_addr, mem_rd
    );

    modport master (
        output ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd, mem_data,
        input  ba_ack, ba_dst, ba_dok, ba_rdy, data_read, mem_addr, mem_rd
    );
endinterface

// File: rtl/jtvigil_sdram_resp.sv
// Round-robin four-bank SDRAM read responder serialising bursts onto one
// fixed-latency memory read port.
//
// state | meaning
// IDLE  | sample ba_rd, grant next bank in pointer order
// ISSUE | one mem_rd per cycle for BURST words, ack in first cycle
// DRAIN | wait for the last tagged word to come back
module jtvigil_sdram_resp #(
    parameter int LATENCY = 2,
    parameter int BURST   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    jtvigil_sdram_resp_if.slave   bus,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t      state_q;
    logic [1:0]  ptr_q;
    logic [1:0]  g_q;
    logic [3:0]  cnt_q;
    logic        mem_rd_q;
    logic        first_q;
    logic        last_q;
    logic [21:0] mem_addr_q;
    logic [3:0]  ack_q;
    logic [3:0]  dst_q;
    logic [3:0]  dok_q;
    logic [3:0]  rdy_q;
    logic [15:0] data_q;
    logic [2:0]  tag_q [LATENCY];

    logic        gnt_vld_d;
    logic [1:0]  gnt_d;
    logic [21:0] addr_d;

    // Descending scan so the lowest offset from the pointer wins.
    always_comb begin
        gnt_vld_d = 1'b0;
        gnt_d     = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (bus.ba_rd[ptr_q + 2'(i)]) begin
                gnt_vld_d = 1'b1;
                gnt_d     = ptr_q + 2'(i);
            end
        end
        case (gnt_d)
            2'd0:    addr_d = bus.ba0_addr;
            2'd1:    addr_d = bus.ba1_addr;
            2'd2:    addr_d = bus.ba2_addr;
            default: addr_d = bus.ba3_addr;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            g_q        <= 2'd0;
            cnt_q      <= 4'd0;
            mem_rd_q   <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            mem_addr_q <= 22'd0;
            ack_q      <= 4'd0;
            dst_q      <= 4'd0;
            dok_q      <= 4'd0;
            rdy_q      <= 4'd0;
            data_q     <= 16'd0;
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= 3'd0;
        end else begin
            ack_q    <= 4'd0;
            tag_q[0] <= {mem_rd_q, first_q, last_q};
            for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];

            // Tag at the pipe end marks mem_data as valid this cycle.
            if (tag_q[LATENCY-1][2]) begin
                data_q <= bus.mem_data;
                dok_q  <= 4'b0001 << g_q;
                dst_q  <= tag_q[LATENCY-1][1] ? (4'b0001 << g_q) : 4'd0;
                rdy_q  <= tag_q[LATENCY-1][0] ? (4'b0001 << g_q) : 4'd0;
            end else begin
                dok_q <= 4'd0;
                dst_q <= 4'd0;
                rdy_q <= 4'd0;
            end

            case (state_q)
                IDLE: begin
                    if (gnt_vld_d) begin
                        g_q        <= gnt_d;
                        ptr_q      <= gnt_d + 2'd1;
                        ack_q      <= 4'b0001 << gnt_d;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= addr_d;
                        first_q    <= 1'b1;
                        last_q     <= (BURST == 1);
                        cnt_q      <= 4'(BURST - 1);
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    first_q <= 1'b0;
                    if (cnt_q == 4'd0) begin
                        mem_rd_q <= 1'b0;
                        last_q   <= 1'b0;
                        state_q  <= DRAIN;
                    end else begin
                        mem_addr_q <= mem_addr_q + 22'd1;
                        last_q     <= (cnt_q == 4'd1);
                        cnt_q      <= cnt_q - 4'd1;
                    end
                end
                DRAIN: begin
                    if (rdy_q != 4'd0) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ba_ack    = ack_q;
    assign bus.ba_dst    = dst_q;
    assign bus.ba_dok    = dok_q;
    assign bus.ba_rdy    = rdy_q;
    assign bus.data_read = data_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rd    = mem_rd_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_jtvigil_sdram_resp.sv
// Scoreboard bench: two responders (LATENCY=2/BURST=2 and LATENCY=1/BURST=1)
// with directed bank requests and a behavioural memory.
module tb_jtvigil_sdram_resp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy0, busy1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    jtvigil_sdram_resp_if if0 ();
    jtvigil_sdram_resp_if if1 ();

    jtvigil_sdram_resp #(.LATENCY(2), .BURST(2)) u0 (.clk(clk), .rst(rst), .bus(if0), .busy_o(busy0));
    jtvigil_sdram_resp #(.LATENCY(1), .BURST(1)) u1 (.clk(clk), .rst(rst), .bus(if1), .busy_o(busy1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] memval(input logic [21:0] a);
        if (a == 22'h10) return 16'hAAAA;
        if (a == 22'h11) return 16'h5555;
        return a[15:0] ^ 16'h3C96;
    endfunction

    // Memory models: data valid LATENCY cycles after mem_rd is sampled.
    logic        p0v0 = 1'b0, p0v1 = 1'b0, p1v = 1'b0;
    logic [21:0] p0a0 = '0, p0a1 = '0, p1a = '0;
    always @(posedge clk) begin
        p0v0 <= if0.mem_rd; p0a0 <= if0.mem_addr;
        p0v1 <= p0v0;       p0a1 <= p0a0;
        p1v  <= if1.mem_rd; p1a  <= if1.mem_addr;
    end
    assign if0.mem_data = p0v1 ? memval(p0a1) : 16'hDEAD;
    assign if1.mem_data = p1v  ? memval(p1a)  : 16'hDEAD;

    typedef struct {
        int          dut;
        int          bank;
        int          cyc;
        logic [21:0] addr;
        logic [15:0] data;
        logic        first;
        logic        last;
    } exp_t;

    exp_t ack_q [$];
    exp_t mem_q [$];
    exp_t dat_q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_req(input int d, input int bank, input logic [21:0] addr,
                            input int t, input bit with_data);
        exp_t e;
        int lat, bl;
        lat = (d != 0) ? 1 : 2;
        bl  = (d != 0) ? 1 : 2;
        e.dut = d; e.bank = bank; e.cyc = t + 1; e.addr = addr;
        e.data = 16'h0; e.first = 1'b0; e.last = 1'b0;
        ack_q.push_back(e);
        for (int i = 0; i < bl; i++) begin
            e.addr = addr + 22'(i);
            e.cyc  = t + 1 + i;
            mem_q.push_back(e);
            if (with_data) begin
                e.data  = memval(e.addr);
                e.first = (i == 0);
                e.last  = (i == bl - 1);
                e.cyc   = t + lat + 2 + i;
                dat_q.push_back(e);
            end
        end
    endtask

    task automatic mon(input int d, input logic [3:0] ack, input logic [3:0] dst,
                       input logic [3:0] dok, input logic [3:0] rdy, input logic [15:0] dr,
                       input logic mrd, input logic [21:0] ma);
        exp_t e;
        if (ack != 4'd0) begin
            if (ack_q.size() == 0) chk("ack_unexpected", ack, 0);
            else begin
                e = ack_q.pop_front();
                chk("ack_dut", d, e.dut);
                chk("ack_bank", ack, 4'b0001 << e.bank);
                chk("ack_cycle", cyc, e.cyc);
            end
        end
        if (mrd) begin
            if (mem_q.size() == 0) chk("mem_rd_unexpected", mrd, 0);
            else begin
                e = mem_q.pop_front();
                chk("mem_dut", d, e.dut);
                chk("mem_addr", ma, e.addr);
                chk("mem_cycle", cyc, e.cyc);
            end
        end
        if (dok != 4'd0) begin
            if (dat_q.size() == 0) chk("dok_unexpected", dok, 0);
            else begin
                e = dat_q.pop_front();
                chk("dok_dut", d, e.dut);
                chk("dok_vec", dok, 4'b0001 << e.bank);
                chk("dst_vec", dst, e.first ? (4'b0001 << e.bank) : 4'd0);
                chk("rdy_vec", rdy, e.last ? (4'b0001 << e.bank) : 4'd0);
                chk("data_read", dr, e.data);
                chk("dok_cycle", cyc, e.cyc);
            end
        end else if ((dst | rdy) != 4'd0) begin
            chk("strobe_without_dok", {dst, rdy}, 0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, if0.ba_ack, if0.ba_dst, if0.ba_dok, if0.ba_rdy, if0.data_read, if0.mem_rd, if0.mem_addr);
        mon(1, if1.ba_ack, if1.ba_dst, if1.ba_dok, if1.ba_rdy, if1.data_read, if1.mem_rd, if1.mem_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles; acked banks drop their request unless held.
    task automatic run(input int d, input int n, input logic [3:0] hold);
        for (int i = 0; i < n; i++) begin
            step();
            if (d == 0) if0.ba_rd = if0.ba_rd & ~(if0.ba_ack & ~hold);
            else        if1.ba_rd = if1.ba_rd & ~(if1.ba_ack & ~hold);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    function automatic logic [63:0] outs0();
        return {if0.ba_ack, if0.ba_dst, if0.ba_dok, if0.ba_rdy, if0.data_read,
                if0.mem_addr, if0.mem_rd, busy0};
    endfunction

    function automatic logic [63:0] outs1();
        return {if1.ba_ack, if1.ba_dst, if1.ba_dok, if1.ba_rdy, if1.data_read,
                if1.mem_addr, if1.mem_rd, busy1};
    endfunction

    int t0;

    initial begin
        if0.ba_rd = 4'd0; if1.ba_rd = 4'd0;
        if0.ba0_addr = '0; if0.ba1_addr = '0; if0.ba2_addr = '0; if0.ba3_addr = '0;
        if1.ba0_addr = '0; if1.ba1_addr = '0; if1.ba2_addr = '0; if1.ba3_addr = '0;
        step();
        chk("reset_outputs0", outs0(), 0);
        chk("reset_outputs1", outs1(), 0);
        rst = 1'b0;
        step();

        // Single request on bank 1
        t0 = cyc;
        if0.ba1_addr = 22'h10;
        if0.ba_rd = 4'b0010;
        push_req(0, 1, 22'h10, t0, 1'b1);
        chk("busy_idle", busy0, 1'b0);
        run(0, 5, 4'd0);
        chk("busy_drain", busy0, 1'b1);
        run(0, 1, 4'd0);
        chk("busy_fall", busy0, 1'b0);
        run(0, 2, 4'd0);

        // All four banks at once, bank 3 wraps the address space
        do_reset();
        t0 = cyc;
        if0.ba0_addr = 22'h100; if0.ba1_addr = 22'h200;
        if0.ba2_addr = 22'h300; if0.ba3_addr = 22'h3FFFFF;
        if0.ba_rd = 4'hF;
        push_req(0, 0, 22'h100,    t0,      1'b1);
        push_req(0, 1, 22'h200,    t0 + 6,  1'b1);
        push_req(0, 2, 22'h300,    t0 + 12, 1'b1);
        push_req(0, 3, 22'h3FFFFF, t0 + 18, 1'b1);
        run(0, 26, 4'd0);

        // Fairness: banks 0 and 2 held; bank 0 address changes after its ack
        do_reset();
        t0 = cyc;
        if0.ba0_addr = 22'h40; if0.ba2_addr = 22'h80;
        if0.ba_rd = 4'b0101;
        push_req(0, 0, 22'h40,  t0,      1'b1);
        push_req(0, 2, 22'h80,  t0 + 6,  1'b1);
        push_req(0, 0, 22'h500, t0 + 12, 1'b1);
        push_req(0, 2, 22'h80,  t0 + 18, 1'b1);
        run(0, 2, 4'b0101);
        if0.ba0_addr = 22'h500;
        run(0, 17, 4'b0101);
        if0.ba_rd = 4'd0;
        run(0, 8, 4'd0);

        // BURST=1, LATENCY=1: dst/dok/rdy together, back-to-back grant
        t0 = cyc;
        if1.ba1_addr = 22'h60;
        if1.ba_rd = 4'b0010;
        push_req(1, 1, 22'h60, t0,     1'b1);
        push_req(1, 1, 22'h60, t0 + 4, 1'b1);
        run(1, 5, 4'b0010);
        if1.ba_rd = 4'd0;
        run(1, 4, 4'd0);

        // Reset in cycle 3 of a burst: no data strobes may follow
        t0 = cyc;
        if0.ba2_addr = 22'h20;
        if0.ba_rd = 4'b0100;
        push_req(0, 2, 22'h20, t0, 1'b0);
        run(0, 3, 4'd0);
        rst = 1'b1;
        #1;
        chk("midburst_reset_outputs", outs0(), 0);
        step();
        rst = 1'b0;
        run(0, 6, 4'd0);
        t0 = cyc;
        if0.ba2_addr = 22'h30; if0.ba3_addr = 22'h31;
        if0.ba_rd = 4'b1100;
        push_req(0, 2, 22'h30, t0,     1'b1);
        push_req(0, 3, 22'h31, t0 + 6, 1'b1);
        run(0, 16, 4'd0);

        chk("scoreboard_drained", ack_q.size() + mem_q.size() + dat_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
